// File: rtl/sdram_arbiter.sv
// Arbitrates one SDRAM port between video refill (highest), cache write-back and cache fill, one 256-byte burst at a time.
// Optional VID_FRAME_SYNC_EN: frame_sync forces the video block address back to 0.
module sdram_arbiter #(
    parameter int VID_LAST    = 2399,
    parameter int BURST_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_en,
    input  logic        vid_need,
    input  logic        cache_wr_req,
    input  logic [16:0] cache_wr_adr,
    input  logic        cache_rd_req,
    input  logic [16:0] cache_rd_adr,
    input  logic        frame_sync,
    output logic [1:0]  sdr_cmd,
    output logic [22:0] sdr_addr,
    input  logic [1:0]  sdr_ack,
    input  logic        sdr_rd_valid,
    input  logic        sdr_wr_valid,
    input  logic [15:0] sdr_dout,
    output logic [31:0] vq_data,
    output logic        vq_we,
    output logic        cache_fill,
    output logic        cache_drain,
    output logic [15:0] vid_adr
);
    localparam int CW = $clog2(BURST_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t        state, state_nx;
    logic          owner_vid;
    logic          burst_wr;
    logic          pair_hi;
    logic [15:0]   lo_word;
    logic [CW-1:0] beat_cnt;
    logic          vid_req, any_req, acked, beat, last_beat;

    assign vid_req   = vid_en & vid_need;
    assign any_req   = vid_req | cache_wr_req | cache_rd_req;
    assign acked     = (state == ISSUE) && (sdr_ack == sdr_cmd);
    assign beat      = (state == BURST) && (burst_wr ? sdr_wr_valid : sdr_rd_valid);
    assign last_beat = beat && (beat_cnt == CW'(BURST_WORDS - 1));

    assign cache_fill  = sdr_rd_valid & ~owner_vid & (state == BURST);
    assign cache_drain = sdr_wr_valid & ~owner_vid & (state == BURST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req)   state_nx = ISSUE;
            ISSUE:   if (acked)     state_nx = BURST;
            BURST:   if (last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdr_cmd   <= 2'b00;
            sdr_addr  <= '0;
            owner_vid <= 1'b0;
            burst_wr  <= 1'b0;
            pair_hi   <= 1'b0;
            lo_word   <= '0;
            beat_cnt  <= '0;
            vq_data   <= '0;
            vq_we     <= 1'b0;
        end else begin
            vq_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (vid_req) begin
                        sdr_cmd   <= 2'b10;
                        sdr_addr  <= {1'b1, vid_adr, 6'b0};
                        owner_vid <= 1'b1;
                        burst_wr  <= 1'b0;
                    end else if (cache_wr_req) begin
                        sdr_cmd   <= 2'b01;
                        sdr_addr  <= {cache_wr_adr, 6'b0};
                        owner_vid <= 1'b0;
                        burst_wr  <= 1'b1;
                    end else if (cache_rd_req) begin
                        sdr_cmd   <= 2'b11;
                        sdr_addr  <= {cache_rd_adr, 6'b0};
                        owner_vid <= 1'b0;
                        burst_wr  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Pair phase restarts here so every burst fills the low half first.
                    if (acked) begin
                        sdr_cmd  <= 2'b00;
                        beat_cnt <= '0;
                        pair_hi  <= 1'b0;
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (owner_vid) begin
                            pair_hi <= ~pair_hi;
                            if (!pair_hi) begin
                                lo_word <= sdr_dout;
                            end else begin
                                vq_data <= {sdr_dout, lo_word};
                                vq_we   <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_adr <= '0;
        end else begin
            if (acked && owner_vid)
                vid_adr <= (vid_adr == 16'(VID_LAST)) ? 16'd0 : vid_adr + 16'd1;
`ifdef VID_FRAME_SYNC_EN
            if (frame_sync)
                vid_adr <= '0;
`endif
        end
    end

`ifndef VID_FRAME_SYNC_EN
    logic frame_sync_unused;
    assign frame_sync_unused = frame_sync;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: grant table, multi-cycle corner sequences, then randomized transactions
// checked against a transaction-level model of grant priority, addresses, word pairing and the video address counter.
module tb_sdram_arbiter;
    localparam int VID_LAST_T = 19;
    localparam int BW         = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_en, vid_need, cache_wr_req, cache_rd_req, frame_sync;
    logic [16:0] cache_wr_adr, cache_rd_adr;
    logic [1:0]  sdr_cmd, sdr_ack;
    logic [22:0] sdr_addr;
    logic        sdr_rd_valid, sdr_wr_valid;
    logic [15:0] sdr_dout, vid_adr;
    logic [31:0] vq_data;
    logic        vq_we, cache_fill, cache_drain;

    int checks = 0;
    int errors = 0;
    int m_vid  = 0;

    sdram_arbiter #(.VID_LAST(VID_LAST_T), .BURST_WORDS(BW)) dut (
        .clk(clk), .rst(rst),
        .vid_en(vid_en), .vid_need(vid_need),
        .cache_wr_req(cache_wr_req), .cache_wr_adr(cache_wr_adr),
        .cache_rd_req(cache_rd_req), .cache_rd_adr(cache_rd_adr),
        .frame_sync(frame_sync),
        .sdr_cmd(sdr_cmd), .sdr_addr(sdr_addr),
        .sdr_ack(sdr_ack), .sdr_rd_valid(sdr_rd_valid), .sdr_wr_valid(sdr_wr_valid), .sdr_dout(sdr_dout),
        .vq_data(vq_data), .vq_we(vq_we),
        .cache_fill(cache_fill), .cache_drain(cache_drain), .vid_adr(vid_adr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        en, need, wr;
        logic [16:0] wadr;
        logic        rd;
        logic [16:0] radr;
        logic [1:0]  cmd;
        logic [22:0] addr;
        logic        seq;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_cmd_f(logic en, logic need, logic wr, logic rd);
        if (en && need) return 2'b10;
        if (wr)         return 2'b01;
        if (rd)         return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [22:0] exp_addr_f(logic [1:0] c, logic [16:0] wa, logic [16:0] ra);
        case (c)
            2'b10:   return 23'(32'h400000 + m_vid * 64);
            2'b01:   return 23'(wa * 64);
            default: return 23'(ra * 64);
        endcase
    endfunction

    task automatic run_txn(input logic en, input logic need, input logic wr, input logic [16:0] wadr,
                           input logic rd, input logic [16:0] radr, input logic [1:0] ecmd,
                           input logic [22:0] eaddr, input bit seq, input bit fs);
        int n_wrong, beats, strobes, fills, drains, guard;
        bit half, v, exp_we, vid, wrb;
        logic [15:0] lo, d;
        logic [31:0] exp_dat;
        logic [1:0]  bad;
        vid = (ecmd == 2'b10);
        wrb = (ecmd == 2'b01);
        lo = '0;
        exp_dat = '0;
        vid_en = en; vid_need = need; cache_wr_req = wr; cache_wr_adr = wadr;
        cache_rd_req = rd; cache_rd_adr = radr;
        sdr_rd_valid = 0; sdr_wr_valid = 0; sdr_ack = 0;
        tick();
        chk("grant_cmd", 32'(sdr_cmd), 32'(ecmd));
        chk("grant_addr", 32'(sdr_addr), 32'(eaddr));
        n_wrong = $urandom_range(0, 3);
        for (int i = 0; i < n_wrong; i++) begin
            do bad = 2'($urandom); while (bad == ecmd);
            sdr_ack = bad;
            sdr_rd_valid = 1'($urandom_range(0, 1));
            sdr_wr_valid = 1'($urandom_range(0, 1));
            #1 chk("issue_fill_drain", {30'b0, cache_fill, cache_drain}, 0);
            tick();
            chk("issue_hold_cmd", 32'(sdr_cmd), 32'(ecmd));
            chk("issue_hold_addr", 32'(sdr_addr), 32'(eaddr));
            chk("issue_vq_we", 32'(vq_we), 0);
        end
        sdr_ack = ecmd; sdr_rd_valid = 0; sdr_wr_valid = 0; frame_sync = fs;
        vid_en = 0; vid_need = 0; cache_wr_req = 0; cache_rd_req = 0;
        tick();
        sdr_ack = 0; frame_sync = 0;
        if (vid) m_vid = (m_vid + 1) % (VID_LAST_T + 1);
`ifdef VID_FRAME_SYNC_EN
        if (fs) m_vid = 0;
`endif
        chk("ack_cmd_nop", 32'(sdr_cmd), 0);
        chk("vid_adr", 32'(vid_adr), 32'(m_vid));
        beats = 0; half = 0; strobes = 0; fills = 0; drains = 0; guard = 0;
        while (beats < BW && guard < 4000) begin
            guard++;
            v = ($urandom_range(0, 3) != 0);
            d = seq ? 16'(beats + 1) : 16'($urandom);
            sdr_dout = d;
            sdr_rd_valid = v && !wrb;
            sdr_wr_valid = v && wrb;
            #1;
            fills  += int'(cache_fill);
            drains += int'(cache_drain);
            exp_we = 0;
            if (v) begin
                beats++;
                if (vid) begin
                    if (!half) lo = d;
                    else begin
                        exp_we = 1;
                        exp_dat = {d, lo};
                    end
                    half = !half;
                end
            end
            tick();
            chk("vq_we", 32'(vq_we), 32'(exp_we));
            if (exp_we) chk("vq_data", vq_data, exp_dat);
            strobes += int'(vq_we);
        end
        sdr_rd_valid = 0; sdr_wr_valid = 0;
        chk("burst_beats", beats, BW);
        chk("strobes", strobes, vid ? BW / 2 : 0);
        chk("fills", fills, (ecmd == 2'b11) ? BW : 0);
        chk("drains", drains, wrb ? BW : 0);
        sdr_rd_valid = 1; sdr_wr_valid = 1;
        #1 chk("idle_fill_drain", {30'b0, cache_fill, cache_drain}, 0);
        tick();
        chk("idle_cmd", 32'(sdr_cmd), 0);
        chk("idle_vq_we", 32'(vq_we), 0);
        sdr_rd_valid = 0; sdr_wr_valid = 0;
    endtask

    task automatic vid_txn(input bit fs);
        run_txn(1, 1, 0, 17'h0, 0, 17'h0, 2'b10, 23'(32'h400000 + m_vid * 64), 0, fs);
    endtask

    initial begin
        logic        en, need, wr, rd;
        logic [16:0] wa, ra;
        logic [1:0]  c;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 17'h00010, 1'b1, 17'h00020, 2'b10, 23'h400000, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 17'h00123, 1'b1, 17'h00020, 2'b01, 23'h0048C0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 17'h00000, 1'b1, 17'h1ABCD, 2'b11, 23'h6AF340, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 17'h00000, 1'b0, 17'h00000, 2'b10, 23'h400040, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 17'h1FFFF, 1'b1, 17'h00005, 2'b01, 23'h7FFFC0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 17'h00000, 1'b1, 17'h00001, 2'b11, 23'h000040, 1'b0};

        rst = 1; vid_en = 0; vid_need = 0; cache_wr_req = 0; cache_rd_req = 0;
        cache_wr_adr = 0; cache_rd_adr = 0; frame_sync = 0;
        sdr_ack = 0; sdr_rd_valid = 1; sdr_wr_valid = 1; sdr_dout = 0;
        repeat (3) tick();
        chk("rst_cmd", 32'(sdr_cmd), 0);
        chk("rst_addr", 32'(sdr_addr), 0);
        chk("rst_vid_adr", 32'(vid_adr), 0);
        chk("rst_vq_we", 32'(vq_we), 0);
        chk("rst_vq_data", vq_data, 0);
        chk("rst_fill_drain", {30'b0, cache_fill, cache_drain}, 0);
        rst = 0; sdr_rd_valid = 0; sdr_wr_valid = 0;
        tick();

        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].en, tbl[i].need, tbl[i].wr, tbl[i].wadr, tbl[i].rd, tbl[i].radr,
                    tbl[i].cmd, tbl[i].addr, tbl[i].seq, 0);

        while (m_vid != 17) vid_txn(0);
        chk("vid_adr_17", 32'(vid_adr), 17);
        vid_txn(1);
`ifdef VID_FRAME_SYNC_EN
        chk("frame_sync_vid_adr", 32'(vid_adr), 0);
`else
        chk("frame_sync_vid_adr", 32'(vid_adr), 18);
`endif
        while (m_vid != VID_LAST_T) vid_txn(0);
        vid_txn(0);
        chk("vid_adr_wrap", 32'(vid_adr), 0);

        // Reset in the middle of a video burst
        vid_en = 1; vid_need = 1;
        tick();
        vid_en = 0; vid_need = 0; sdr_ack = 2'b10;
        tick();
        sdr_ack = 0;
        for (int i = 0; i < 40; i++) begin
            sdr_rd_valid = 1;
            sdr_dout = 16'(i + 100);
            tick();
        end
        sdr_rd_valid = 0;
        rst = 1;
        tick();
        chk("midrst_cmd", 32'(sdr_cmd), 0);
        chk("midrst_addr", 32'(sdr_addr), 0);
        chk("midrst_vid_adr", 32'(vid_adr), 0);
        chk("midrst_vq_we", 32'(vq_we), 0);
        chk("midrst_vq_data", vq_data, 0);
        rst = 0;
        m_vid = 0;
        run_txn(1, 1, 0, 17'h0, 0, 17'h0, 2'b10, 23'h400000, 1, 0);

        for (int t = 0; t < 30; t++) begin
            do begin
                en   = 1'($urandom_range(0, 1));
                need = 1'($urandom_range(0, 1));
                wr   = 1'($urandom_range(0, 1));
                rd   = 1'($urandom_range(0, 1));
            end while (exp_cmd_f(en, need, wr, rd) == 2'b00);
            wa = 17'($urandom);
            ra = 17'($urandom);
            c  = exp_cmd_f(en, need, wr, rd);
            run_txn(en, need, wr, wa, rd, ra, c, exp_addr_f(c, wa, ra), 0, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter VID_LAST, default 2399, last video block index (640*480*2/256-1).
REQ-002 SHALL have parameter BURST_WORDS, default 128, 16-bit words per 256-byte burst.
REQ-003 SHALL have ports: clk  in  1  sole clock, SDRAM controller clock domain; all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports: vid_en  in  1  display enabled; vid_need  in  1  video queue almost-empty.
REQ-006 SHALL have ports: cache_wr_req  in  1 and cache_wr_adr  in  17  cache write-back request and 256-byte block address.
REQ-007 SHALL have ports: cache_rd_req  in  1 and cache_rd_adr  in  17  cache fill request and block address.
REQ-008 SHALL have ports: frame_sync  in  1  single-cycle frame-start pulse, already in clk domain.
REQ-009 SHALL have ports: sdr_cmd  out  2 (00 nop, 01 write, 10 video read, 11 cache read); sdr_addr  out  23.
REQ-010 SHALL have ports: sdr_ack  in  2; sdr_rd_valid  in  1; sdr_wr_valid  in  1; sdr_dout  in  16.
REQ-011 SHALL have ports: vq_data  out  32; vq_we  out  1  video queue write strobe.
REQ-012 SHALL have ports: cache_fill  out  1  (read word for cache); cache_drain  out  1  (cache word consumed by SDRAM); vid_adr  out  16.

Function
REQ-013 SHALL implement states IDLE, ISSUE, BURST.
REQ-014 In IDLE, SHALL sample requests with fixed priority: (vid_en & vid_need) > cache_wr_req > cache_rd_req; no request -> stay IDLE, sdr_cmd=00.
REQ-015 On grant, SHALL register sdr_cmd and owner (VIDEO/CACHE) and enter ISSUE the next cycle.
REQ-016 sdr_addr SHALL be {1'b1,vid_adr,6'b0} for 10, {cache_wr_adr,6'b0} for 01, {cache_rd_adr,6'b0} for 11, held constant through ISSUE.
REQ-017 In ISSUE, SHALL hold sdr_cmd until sdr_ack equals sdr_cmd, then drive sdr_cmd=00 the next cycle and enter BURST; other ack values SHALL be ignored.
REQ-018 On the video ack cycle, vid_adr SHALL increment by 1, wrapping VID_LAST -> 0.
REQ-019 In BURST, SHALL count sdr_rd_valid (read) or sdr_wr_valid (write) pulses; after BURST_WORDS pulses return to IDLE; next grant no earlier than the following cycle.
REQ-020 cache_fill SHALL equal sdr_rd_valid & owner CACHE & state BURST; cache_drain SHALL equal sdr_wr_valid & owner CACHE & state BURST (combinational).
REQ-021 Video words SHALL pack in pairs: first valid word to low half, second to high half; vq_data={second,first}, vq_we high one cycle after the second word; 64 strobes per burst.
REQ-022 Pair phase SHALL clear at each video ack, so a burst always starts on the low half.
REQ-023 vid_en deasserted mid-burst SHALL NOT abort; burst completes, no new video grants.
REQ-024 Valid pulses in IDLE or ISSUE SHALL be ignored (no strobes, no counting).

Reset
REQ-025 On rst: state IDLE, sdr_cmd=00, sdr_addr=0, vid_adr=0, vq_we=0, vq_data=0, burst count and pair phase 0, owner CACHE; applies mid-burst.

Configuration
REQ-026 Macro VID_FRAME_SYNC_EN defined: frame_sync sets vid_adr=0, winning over a same-cycle increment; undefined: frame_sync ignored, vid_adr only wraps per REQ-018.

Verification
REQ-027 vid_need, cache_wr_req, cache_rd_req all high in IDLE -> sdr_cmd=10, sdr_addr=0x400000 (vid_adr=0); after 128 rd_valid, cache write granted.
REQ-028 Video burst with sdr_dout=0x0001,0x0002,... -> first vq_data=0x00020001, 64 vq_we strobes, cache_fill never high.
REQ-029 vid_adr=2399, video ack -> vid_adr=0; 2400 bursts from reset return vid_adr to 0.
REQ-030 cache_rd_adr=0x1ABCD granted -> sdr_addr=0x6AF340, 128 cache_fill pulses, then IDLE.
REQ-031 rst after 40 valid words -> all outputs at reset values next cycle; next video grant starts on low half.
REQ-032 VID_FRAME_SYNC_EN defined, vid_adr=17, frame_sync with ack -> vid_adr=0; undefined -> vid_adr=18.
